// File: rtl/color_sensor_emulator_if.sv
// Configuration bus for the colour sensor emulator.
// The bench or a soft CPU drives the master side and the emulator listens on
// the slave side. A single-cycle cfg_we strobe writes cfg_data into the
// channel register that cfg_sel selects.
interface color_sensor_emulator_if #(
    parameter int CNT_W = 20
);
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_data;

    modport master (output cfg_we, cfg_sel, cfg_data);
    modport slave  (input  cfg_we, cfg_sel, cfg_data);
endinterface

// File: rtl/color_sensor_emulator.sv
// Colour sensor emulator.
// Produces a 50%-duty square wave on sensor_out. Its half period is the base
// value of the channel selected by filter, multiplied by the factor that scale
// selects (x50, x5 or x1). Any change to filter or scale holds the output low
// for SETTLE_CYCLES cycles. scale = 00 powers the output down.
// Optional feature: define EMU_EDGE_CNT_EN to build a 16-bit rising-edge
// counter on edge_count. When it is undefined, edge_count is tied to zero.
module color_sensor_emulator #(
    parameter int CNT_W         = 20,
    parameter int SETTLE_CYCLES = 100,
    parameter int DEF_HALF      = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             filter,
    input  logic [1:0]             scale,
    color_sensor_emulator_if.slave cfg,
    output logic                   sensor_out,
    output logic                   settling,
    output logic [15:0]            edge_count
);

    localparam int HW = CNT_W + 6;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] base [4];
    logic [3:0]       prev_sel;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [HW-1:0]    half_cnt, half_nxt;
    logic             sensor_nxt;
    logic [5:0]       mult;
    logic [HW-1:0]    h_val;
    logic             sel_change;

    // Translate the scale code into a multiplier. Power-down uses zero.
    always_comb begin
        mult = 6'd0;
        case (scale)
            2'b01:   mult = 6'd50;
            2'b10:   mult = 6'd5;
            2'b11:   mult = 6'd1;
            default: mult = 6'd0;
        endcase
    end

    assign h_val      = HW'(base[filter]) * HW'(mult);
    assign sel_change = ({filter, scale} != prev_sel);

    // Channel registers. A write only changes the value seen at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                base[i] <= CNT_W'(DEF_HALF);
            end
        end else if (cfg.cfg_we) begin
            base[cfg.cfg_sel] <= cfg.cfg_data;
        end
    end

    // Remember last cycle's filter/scale so that any change is detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel <= 4'b0000;
        end else begin
            prev_sel <= {filter, scale};
        end
    end

    // Next-state and output logic: settle sequencing, half-period reload and toggling.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        half_nxt   = half_cnt;
        sensor_nxt = sensor_out;
        case (state)
            OFF: begin
                sensor_nxt = 1'b0;
                if (scale != 2'b00) begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
            end
            SETTLE: begin
                sensor_nxt = 1'b0;
                if (sel_change) begin
                    state_nxt  = (scale == 2'b00) ? OFF : SETTLE;
                    settle_nxt = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt  = RUN;
                    settle_nxt = '0;
                    half_nxt   = h_val;
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            RUN: begin
                if (sel_change) begin
                    state_nxt  = (scale == 2'b00) ? OFF : SETTLE;
                    settle_nxt = '0;
                    sensor_nxt = 1'b0;
                end else if (half_cnt == '0) begin
                    sensor_nxt = 1'b0;
                    half_nxt   = h_val;
                end else if (half_cnt == HW'(1)) begin
                    half_nxt   = h_val;
                    sensor_nxt = (h_val == '0) ? 1'b0 : ~sensor_out;
                end else begin
                    half_nxt = half_cnt - HW'(1);
                end
            end
            default: begin
                state_nxt  = OFF;
                sensor_nxt = 1'b0;
            end
        endcase
    end

    // State and counter registers. settling is decoded from the next state so that it lines up with SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            settle_cnt <= '0;
            half_cnt   <= '0;
            sensor_out <= 1'b0;
            settling   <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            half_cnt   <= half_nxt;
            sensor_out <= sensor_nxt;
            settling   <= (state_nxt == SETTLE);
        end
    end

`ifdef EMU_EDGE_CNT_EN
    // Count the 0->1 transitions of sensor_out. The count wraps and is cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count <= 16'd0;
        end else if (sensor_nxt && !sensor_out) begin
            edge_count <= edge_count + 16'd1;
        end
    end
`else
    assign edge_count = 16'd0;
`endif

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Testbench for color_sensor_emulator.
// Each stimulus step pushes the intervals it expects into a scoreboard queue.
// The expected values come from a behavioural model: per channel base values
// times the scale factor. A negedge monitor measures the settle lengths and
// the intervals between toggles of sensor_out, and compares each one with the
// next entry in the queue. Point checks are queued to the same monitor.
`timescale 1ns/1ps
module tb_color_sensor_emulator;

    localparam int CNT_W  = 20;
    localparam int SETTLE = 100;
    localparam int DEF    = 1000;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [1:0]  filter = 2'b00;
    logic [1:0]  scale  = 2'b00;
    logic        sensor_out;
    logic        settling;
    logic [15:0] edge_count;

    color_sensor_emulator_if #(.CNT_W(CNT_W)) cfg_bus ();

    color_sensor_emulator #(
        .CNT_W(CNT_W),
        .SETTLE_CYCLES(SETTLE),
        .DEF_HALF(DEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .filter(filter),
        .scale(scale),
        .cfg(cfg_bus),
        .sensor_out(sensor_out),
        .settling(settling),
        .edge_count(edge_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        int    kind;
        int    val;
        string name;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    req;
    } chk_t;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   model_base [4];

    int   cyc          = 0;
    int   ref_cyc      = 0;
    int   settle_start = 0;
    int   rise_total   = 0;
    logic prev_out     = 1'b0;
    logic prev_set     = 1'b0;

    // Half period in clk cycles, taken from the channel base and the scale factor.
    function automatic int modelHalf(input logic [1:0] f, input logic [1:0] s);
        int m;
        case (s)
            2'b01:   m = 50;
            2'b10:   m = 5;
            2'b11:   m = 1;
            default: m = 0;
        endcase
        return model_base[f] * m;
    endfunction

    function automatic void requestCheck(input string nm, input int act, input int req);
        chk_t c;
        c.name = nm;
        c.act  = act;
        c.req  = req;
        chk_q.push_back(c);
    endfunction

    function automatic void pushHalf(input string nm, input int val);
        exp_t e;
        e.kind = 1;
        e.val  = val;
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    task automatic checkOutput(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic observe(input int kind, input int val);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (kind != e.kind) begin
                checkOutput({e.name, "_event_kind"}, kind, e.kind);
            end else begin
                checkOutput(e.name, val, e.val);
            end
        end
    endtask

    // Monitor: measure settle lengths and toggle intervals, then score them.
    always @(negedge clk) begin
        chk_t c;
        cyc++;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checkOutput(c.name, c.act, c.req);
        end
        if (!rst_n) begin
            rise_total = 0;
        end else if (sensor_out && !prev_out) begin
            rise_total++;
        end
        if (settling && !prev_set) begin
            settle_start = cyc;
        end
        if (!settling && prev_set) begin
            observe(0, cyc - settle_start);
            ref_cyc = cyc;
        end
        if (sensor_out != prev_out) begin
            observe(1, cyc - ref_cyc);
            ref_cyc = cyc;
        end
        prev_out = sensor_out;
        prev_set = settling;
    end

    task automatic applyStimulus(input logic [1:0] f, input logic [1:0] s, input logic we,
                                 input logic [1:0] sel, input int data);
        @(posedge clk);
        #1;
        filter           = f;
        scale            = s;
        cfg_bus.cfg_we   = we;
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_data = CNT_W'(data);
        if (we) model_base[sel] = data;
        @(posedge clk);
        #1;
        cfg_bus.cfg_we = 1'b0;
    endtask

    task automatic expectRun(input int settle_len, input int halves, input string tag);
        exp_t e;
        int   h;
        @(negedge clk);
        #1;
        h = modelHalf(filter, scale);
        if (settle_len > 0) begin
            e.kind = 0;
            e.val  = settle_len;
            e.name = {tag, "_settle"};
            exp_q.push_back(e);
        end
        for (int i = 0; i < halves; i++) begin
            pushHalf($sformatf("%s_half%0d", tag, i), h);
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            requestCheck({tag, "_timeout_pending"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic waitRise(input int budget, input string nm);
        logic p;
        bit   seen;
        int   n;
        p    = sensor_out;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (sensor_out && !p) seen = 1'b1;
            p = sensor_out;
        end
        requestCheck(nm, int'(seen), 1);
    endtask

    task automatic quietCheck(input int cycles, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (sensor_out) bad++;
        end
        requestCheck(nm, bad, 0);
    endtask

    task automatic edgeCheck(input string nm);
        @(negedge clk);
        #1;
`ifdef EMU_EDGE_CNT_EN
        requestCheck(nm, int'(edge_count), rise_total & 16'hFFFF);
`else
        requestCheck(nm, int'(edge_count), 0);
`endif
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        int bad;
        logic [1:0] f, s, wsel;
        logic       we;
        int         wdata;

        for (int i = 0; i < 4; i++) model_base[i] = DEF;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_sel  = 2'b00;
        cfg_bus.cfg_data = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        requestCheck("reset_sensor_out", int'(sensor_out), 0);
        requestCheck("reset_settling", int'(settling), 0);
        requestCheck("reset_edge_count", int'(edge_count), 0);
        rst_n = 1'b1;

        $display("[TB] default timing after reset");
        applyStimulus(2'b00, 2'b11, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 3, "default");
        drain(5000, "default");
        edgeCheck("edge_count_default");

        $display("[TB] programmed channels and scaling");
        applyStimulus(filter, scale, 1'b1, 2'b01, 40);
        applyStimulus(filter, scale, 1'b1, 2'b11, 7);
        applyStimulus(2'b01, 2'b10, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 3, "blue_x5");
        drain(2000, "blue_x5");
        applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 4, "green_x1");
        drain(1000, "green_x1");
        applyStimulus(2'b11, 2'b01, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 3, "green_x50");
        drain(3000, "green_x50");

        $display("[TB] power-down mid high phase");
        waitRise(1000, "pd_wait_rise");
        repeat (100) @(posedge clk);
        applyStimulus(2'b11, 2'b00, 1'b0, 2'b00, 0);
        requestCheck("pd_sensor_low_next_cycle", int'(sensor_out), 0);
        requestCheck("pd_settling_low", int'(settling), 0);
        quietCheck(60, "pd_off_quiet");
        applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 3, "pd_resume");
        drain(1000, "pd_resume");

        $display("[TB] live reconfiguration");
        applyStimulus(2'b00, 2'b11, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 1, "live_pre");
        drain(2000, "live_pre");
        repeat (300) @(posedge clk);
        pushHalf("live_current_half", DEF);
        for (int i = 0; i < 4; i++) pushHalf($sformatf("live_new_half%0d", i), 10);
        applyStimulus(2'b00, 2'b11, 1'b1, 2'b00, 10);
        drain(2000, "live_new");
        applyStimulus(2'b00, 2'b11, 1'b1, 2'b00, 0);
        repeat (30) @(negedge clk);
        quietCheck(50, "zero_base_quiet");
        applyStimulus(2'b00, 2'b11, 1'b1, 2'b00, 5);
        waitRise(50, "zero_base_resume_rise");
        for (int i = 0; i < 4; i++) pushHalf($sformatf("resume_half%0d", i), modelHalf(2'b00, 2'b11));
        drain(200, "resume");
        edgeCheck("edge_count_live");

        $display("[TB] filter changes during settle");
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 2'b01 : 2'b00, 2'b11, 1'b0, 2'b00, 0);
            for (int j = 0; j < 48; j++) begin
                @(posedge clk);
                #1;
                if (!settling || sensor_out) bad++;
            end
        end
        requestCheck("settle_held_during_toggles", bad, 0);
        expectRun(9 * 50 + SETTLE, 3, "toggle_final");
        drain(1000, "toggle_final");

        $display("[TB] reset mid run");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        requestCheck("midrun_reset_sensor_out", int'(sensor_out), 0);
        requestCheck("midrun_reset_settling", int'(settling), 0);
        requestCheck("midrun_reset_edge_count", int'(edge_count), 0);
        for (int i = 0; i < 4; i++) model_base[i] = DEF;
        filter = 2'b00;
        scale  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 0);
        expectRun(SETTLE, 2, "after_reset");
        drain(3000, "after_reset");

        $display("[TB] randomized channel and scale changes");
        for (int ch = 0; ch < 4; ch++) begin
            applyStimulus(filter, scale, 1'b1, 2'(ch), int'($urandom_range(1, 20)));
        end
        for (int it = 0; it < 6; it++) begin
            f     = 2'($urandom_range(0, 3));
            s     = 2'($urandom_range(1, 3));
            we    = 1'($urandom_range(0, 1));
            wsel  = 2'($urandom_range(0, 3));
            wdata = int'($urandom_range(1, 20));
            if (f == filter && s == scale) s = (s == 2'b11) ? 2'b01 : s + 2'b01;
            applyStimulus(f, s, we, wsel, wdata);
            expectRun(SETTLE, 3, $sformatf("rand%0d", it));
            drain(5000, $sformatf("rand%0d", it));
        end
        edgeCheck("edge_count_final");

        repeat (3) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/color_sensor_emulator.md
Name: color_sensor_emulator

Overview:
Synthesizable stand-in for the optical colour sensor on the rover. It takes the same `filter` and `scale` select lines that the sensor-reading logic drives. It outputs a 50%-duty square wave on `sensor_out` whose frequency is programmed per colour channel. It is used on hardware-in-the-loop benches and FPGA self-test builds, so the colour classifier can be exercised without the physical sensor.

Parameters:
- CNT_W, 20, width of each per-channel half-period register (clk cycles at 100% scale).
- SETTLE_CYCLES, 100, cycles `sensor_out` is held low after any filter/scale change; must be ≥1.
- DEF_HALF, 1000, reset value of all four channel half-period registers.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- filter  in  2  photodiode select: 00 red, 01 blue, 11 green, 10 clear.
- scale  in  2  output scaling: 00 power-down, 01 2% (x50), 10 20% (x5), 11 100% (x1).
- cfg_we  in  1  single-cycle write strobe for a channel register.
- cfg_sel  in  2  channel addressed by a write; same encoding as `filter`.
- cfg_data  in  CNT_W  half-period value to write.
- sensor_out  out  1  emulated sensor frequency output.
- settling  out  1  high while in SETTLE.
- edge_count  out  16  rising edges emitted on `sensor_out` (see optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - sensor_out=0, settling=0, edge_count=0, state=OFF.
  - All four channel registers = DEF_HALF.
  - Registered previous {filter, scale} = {00, 00}.
- Inputs: filter and scale are sampled every clk with no synchronizer; they are assumed synchronous to clk.
- Effective half-period: H = base[filter] * mult(scale).
  - mult is 50, 5 or 1 per the scale encoding.
  - The product is computed at CNT_W+6 bits, unsigned, with no saturation.
- States: OFF, SETTLE, RUN.
- OFF:
  - sensor_out=0.
  - When scale != 00: go to SETTLE and clear the settle counter.
- SETTLE:
  - sensor_out=0, settling=1.
  - The settle counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE: go to RUN, load the half counter with H, sensor_out stays 0.
- RUN:
  - The half counter decrements each cycle.
  - On the cycle the counter equals 1: toggle sensor_out and reload H.
  - First rising edge occurs H cycles after RUN entry; period is 2H; duty is exactly 50%.
- Change detect:
  - Any difference between current and registered-previous {filter, scale}, in SETTLE or RUN, forces a transition on the next edge.
  - If the new scale is 00: go to OFF, sensor_out=0 immediately.
  - Otherwise: go to SETTLE, sensor_out=0 immediately, settle counter cleared.
  - A change during SETTLE restarts the settle count.
- Zero base: if H evaluates to 0 at RUN entry or reload, sensor_out is held 0 and the counter is reloaded every cycle, so there is no oscillation. A later nonzero write resumes oscillation at the next reload.
- Config writes:
  - cfg_we writes cfg_data to channel cfg_sel in one cycle, in any state.
  - A write to the active channel does not alter the current half period; the new H takes effect at the next reload or RUN entry (glitch-free).
  - If a write and a filter/scale change occur in the same cycle, both apply; the written value is used at the subsequent RUN entry.
- `settling` is a registered decode of state == SETTLE.

Optional Feature:
- Macro: EMU_EDGE_CNT_EN.
- Defined:
  - edge_count increments on every 0->1 transition of sensor_out, wrapping 0xFFFF->0x0000.
  - It is cleared only by reset, and is not cleared by filter/scale changes.
- Undefined: edge_count is tied to 0 and the counter logic is not synthesized.

Test Plan:
1. Reset default timing: reset, filter=00, scale=11 → settling high for 100 cycles; first rise 1000 cycles after RUN entry; period 2000 cycles, high time 1000.
2. Programmed channels and scaling:
   - Write blue=40 and green=7; select filter=01, scale=10 → period 400.
   - Switch to filter=11 → output low for 100 cycles, then period 14.
   - scale=01 with green → period 700.
3. Power-down: scale=00 mid-high phase → sensor_out=0 the next cycle and state OFF. scale back to 11 → 100-cycle settle, then oscillation resumes.
4. Live reconfiguration:
   - Write the active channel from 1000 to 10 mid-half-period → the current half completes at 1000 cycles, subsequent halves are 10.
   - Write base=0 → output stays low.
   - Write 5 → 10-cycle period resumes.
5. Changes during SETTLE and reset:
   - Toggle filter every 50 cycles for 500 cycles → settling stays high and no edges appear.
   - Assert rst_n low mid-RUN → all outputs 0 immediately, registers back to 1000.
6. Edge counter (EMU_EDGE_CNT_EN):
   - 65536 rising edges with base=1, scale=11 → edge_count wraps to 0.
   - With the macro undefined → edge_count constant 0.
